l2_request_arbiter: RTL
=======================

# l2_request_arbiter

Two-core arbiter and sequencer for the shared 2-way set-associative L2 cache. It accepts load-lookup and flush (write-back) requests from the two L1 cache controllers and grants the L2 to one core at a time using round-robin order. It drives the L2 request bus, tracks L2 hit/miss status through the DMEM refill, and returns a completion pulse plus load data to the owning core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum number of MISS_WAIT cycles before the request is aborted.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- coreN_req  in  1  (N=0,1) request, sampled only in IDLE.
- coreN_flush  in  1  1 = flush/write-back request, 0 = load lookup.
- coreN_address  in  32  request address.
- coreN_data  in  32  write-back data (flush only).
- coreN_tag  in  24  write-back tag (flush only).
- coreN_gnt  out  1  one-cycle pulse: the request was accepted and latched.
- coreN_done  out  1  one-cycle pulse: the request completed.
- coreN_rdata  out  32  load data, valid while coreN_done is high; held until the next done to the same core.
- l2_opcode  out  7  0000011 during a load issue or miss wait; 0000000 otherwise.
- l2_flush  out  1  high for exactly one cycle per flush request.
- l2_address  out  32  latched request address.
- l2_data  out  32  latched request data.
- l2_tag  out  24  latched request tag.
- l2_hit  in  2  L2 status: 10 = hit, 01 = miss, 00 = idle.
- l2_rdata  in  32  L2 load data.
- timeout_err  out  1  sticky flag: a miss wait timed out.

## Operation
- The FSM has four states: IDLE, ISSUE, MISS_WAIT, RESP.
- IDLE: if any coreN_req is high, select a winner. With a single requester, that core wins. With both requesters, the core equal to rr_ptr wins (rr_ptr = 0 after reset).
  - Latch the winner's flush, address, data and tag into owner registers.
  - Set the owner ID and go to ISSUE.
- ISSUE: pulse gnt to the owner.
  - Flush: l2_flush = 1 and l2_opcode = 0. Go to RESP.
  - Load: l2_opcode = 0000011.
    - If l2_hit = 10: capture l2_rdata and go to RESP.
    - Otherwise (01 or 00): clear the counter and go to MISS_WAIT.
- MISS_WAIT: hold l2_opcode = 0000011 and keep the address stable while the L2 refills from DMEM.
  - l2_hit = 10: capture l2_rdata and go to RESP.
  - Otherwise: increment the counter.
  - If no hit is seen on the TIMEOUT_CYCLES-th MISS_WAIT cycle: set timeout_err, capture rdata = 0, go to RESP.
- RESP: pulse done to the owner with rdata driven. Set rr_ptr = ~owner, then go to IDLE.
- l2_address, l2_data and l2_tag hold the latched values in every state, so the L2 set index stays stable through its refill. Only l2_opcode and l2_flush are qualified by state.
- Requesters must deassert req on or before the cycle after gnt. A req still high in RESP is ignored; it is seen again in IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- timeout_err is cleared only by reset.

## Timing
- Reset (reset = 0 at posedge) takes effect from any state, including mid-miss:
  - state = IDLE, rr_ptr = 0, counter = 0.
  - All outputs = 0: gnt, done, rdata, l2_opcode, l2_flush, l2_address, l2_data, l2_tag, timeout_err.
  - The in-flight request is dropped with no done pulse.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Load hit: req is seen at edge T. ISSUE and gnt occupy cycle T+1, l2_hit is sampled at edge T+2, done is high in cycle T+2. Latency is 2 cycles.
- Flush: gnt at T+1, l2_flush high only in cycle T+1, done at T+2.
- Load miss: done occurs 1 cycle after the first MISS_WAIT cycle in which l2_hit = 10. The minimum is 4 cycles after req (ISSUE, MISS_WAIT with the L2 in its fill state, MISS_WAIT with hit, RESP).
- Back-to-back: IDLE costs one cycle between transactions, so the minimum request spacing is 3 cycles.
- The L2 updates on negedge. l2_hit is sampled on posedge and is stable for half a cycle before sampling.

## Test plan
- Reset: drive random requests, then reset = 0 for 2 cycles. All outputs must be 0, and the first request after release of dual requests goes to core0.
- Load hit, core0 alone: address 0x0000_0104, l2_hit = 10 with l2_rdata = 0xDEAD_BEEF in ISSUE. Expect core0_gnt at T+1, core0_done at T+2 with rdata = 0xDEAD_BEEF, and l2_opcode = 0000011 only in cycle T+1.
- Simultaneous requests: both cores request loads 3 times, all hits. Grants must alternate 0,1,0,1,0,1, each done goes to the granted core, and neither core receives two consecutive grants.
- Load miss: l2_hit = 01 for 2 cycles, then 10 with rdata 0x1234_5678. Expect l2_address held at the request address throughout, done 1 cycle after the hit, rdata = 0x1234_5678.
- Flush plus timeout: core1 flushes with address 0x0000_0208, data 0xCAFE_0001, tag 0xABCDEF. Expect l2_flush for exactly 1 cycle with those values and done 2 cycles after req. Then a load with l2_hit stuck at 01 and TIMEOUT_CYCLES = 4: expect timeout_err = 1 and done with rdata = 0, and timeout_err must stay set through later transactions.
- Reset mid-miss: reset = 0 while in MISS_WAIT. Expect no done pulse, state IDLE, and a new request served normally afterwards.

Source files
------------

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: round-robin arbiter and sequencer giving two L1
// controllers turns on the shared L2 through hit, miss refill or flush.
module l2_request_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core0_req,
   input  logic        core0_flush,
   input  logic [31:0] core0_address,
   input  logic [31:0] core0_data,
   input  logic [23:0] core0_tag,
   output logic        core0_gnt,
   output logic        core0_done,
   output logic [31:0] core0_rdata,
   input  logic        core1_req,
   input  logic        core1_flush,
   input  logic [31:0] core1_address,
   input  logic [31:0] core1_data,
   input  logic [23:0] core1_tag,
   output logic        core1_gnt,
   output logic        core1_done,
   output logic [31:0] core1_rdata,
   output logic [6:0]  l2_opcode,
   output logic        l2_flush,
   output logic [31:0] l2_address,
   output logic [31:0] l2_data,
   output logic [23:0] l2_tag,
   input  logic [1:0]  l2_hit,
   input  logic [31:0] l2_rdata,
   output logic        timeout_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      MISS_WAIT,
      RESP
   } state_t;

   state_t        state;
   logic          owner;
   logic          own_flush;
   logic          rr_ptr;
   logic [CW-1:0] cnt;

   logic          win;
   logic          sel_flush;
   logic [31:0]   sel_address;
   logic [31:0]   sel_data;
   logic [23:0]   sel_tag;

   logic          hit;
   logic          expire;
   logic          fin;
   logic [31:0]   fin_data;

   // a lone requester always wins; rr_ptr only breaks ties
   always_comb begin
      win = rr_ptr;
      if (core0_req && !core1_req) begin
         win = 1'b0;
      end else if (core1_req && !core0_req) begin
         win = 1'b1;
      end
      sel_flush   = win ? core1_flush   : core0_flush;
      sel_address = win ? core1_address : core0_address;
      sel_data    = win ? core1_data    : core0_data;
      sel_tag     = win ? core1_tag     : core0_tag;
   end

   always_comb begin
      hit    = (l2_hit == 2'b10);
      expire = (state == MISS_WAIT) && !hit && (cnt == CNT_LAST);
      fin    = 1'b0;
      unique case (state)
         ISSUE:     fin = own_flush || hit;
         MISS_WAIT: fin = hit || expire;
         default:   fin = 1'b0;
      endcase
      fin_data = expire ? '0 : l2_rdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         own_flush   <= 1'b0;
         rr_ptr      <= 1'b0;
         cnt         <= '0;
         core0_gnt   <= 1'b0;
         core1_gnt   <= 1'b0;
         core0_done  <= 1'b0;
         core1_done  <= 1'b0;
         core0_rdata <= '0;
         core1_rdata <= '0;
         l2_opcode   <= '0;
         l2_flush    <= 1'b0;
         l2_address  <= '0;
         l2_data     <= '0;
         l2_tag      <= '0;
         timeout_err <= 1'b0;
      end else begin
         core0_gnt  <= 1'b0;
         core1_gnt  <= 1'b0;
         core0_done <= 1'b0;
         core1_done <= 1'b0;
         l2_flush   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (core0_req || core1_req) begin
                  owner      <= win;
                  own_flush  <= sel_flush;
                  l2_address <= sel_address;
                  l2_data    <= sel_data;
                  l2_tag     <= sel_tag;
                  core0_gnt  <= !win;
                  core1_gnt  <= win;
                  l2_flush   <= sel_flush;
                  l2_opcode  <= sel_flush ? '0 : OP_LOAD;
                  state      <= ISSUE;
               end
            end
            ISSUE, MISS_WAIT: begin
               if (fin) begin
                  state      <= RESP;
                  l2_opcode  <= '0;
                  core0_done <= !owner;
                  core1_done <= owner;
                  if (!own_flush && !owner) begin
                     core0_rdata <= fin_data;
                  end
                  if (!own_flush && owner) begin
                     core1_rdata <= fin_data;
                  end
                  if (expire) begin
                     timeout_err <= 1'b1;
                  end
               end else begin
                  state <= MISS_WAIT;
                  if (state == ISSUE) begin
                     cnt <= '0;
                  end else if (cnt != CNT_MAX) begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RESP: begin
               rr_ptr <= !owner;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
